// File: rtl/spi_regfile_periph.sv
// SPI peripheral register file with CIPO readback, selectable CPOL/CPHA and parametrised geometry.
// Pins are synchronised into clk; all frame decoding runs on the synchronised edges.
module spi_regfile_periph #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_r, ncs_sync_r, copi_sync_r;
  logic                   sclk_d_r, ncs_d_r;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   lead_s, trail_s, sample_s, shift_s;
  logic                   ncs_fall_s, ncs_rise_s, commit_s, wr_hit_s;
  logic [2:0]             state_r;
  logic [CNT_W-1:0]       cnt_r, cnt_inc_s;
  logic                   rw_r;
  logic [ADDR_W-1:0]      addr_r, addr_nxt_s, wr_addr_r;
  logic [DATA_W-1:0]      data_r, data_nxt_s, shout_r, rd_val_s;
  logic [DATA_W-1:0]      regs_r [NUM_REGS];
  logic                   cipo_r, cipo_oe_r, wr_pulse_r, frame_err_r;

  // Input synchronisers, reset to the idle pin levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{CPOL}};
      ncs_sync_r  <= {SYNC_STAGES{1'b1}};
      copi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= CPOL;
      ncs_d_r     <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
      sclk_d_r    <= sclk_s;
      ncs_d_r     <= ncs_s;
    end
  end

  assign sclk_s     = sclk_sync_r[SYNC_STAGES-1];
  assign ncs_s      = ncs_sync_r[SYNC_STAGES-1];
  assign copi_s     = copi_sync_r[SYNC_STAGES-1];
  // Leading edge leaves the idle level, trailing edge returns to it
  assign lead_s     = (sclk_s != sclk_d_r) && (sclk_s != CPOL);
  assign trail_s    = (sclk_s != sclk_d_r) && (sclk_s == CPOL);
  assign sample_s   = CPHA ? trail_s : lead_s;
  assign shift_s    = CPHA ? lead_s : trail_s;
  assign ncs_fall_s = ncs_d_r && !ncs_s;
  assign ncs_rise_s = !ncs_d_r && ncs_s;
  assign addr_nxt_s = ADDR_W'({addr_r, copi_s});
  assign data_nxt_s = DATA_W'({data_r, copi_s});
  assign cnt_inc_s  = (cnt_r == CNT_W'(FRAME_LEN)) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign commit_s   = (state_r == ST_DATA) && !ncs_rise_s && sample_s && rw_r &&
                      (cnt_r == CNT_W'(FRAME_LEN - 1));

  // Readback mux and write-address range decode
  always_comb begin
    rd_val_s = {DATA_W{1'b0}};
    wr_hit_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val_s = rd_val_s | ((addr_nxt_s == ADDR_W'(i)) ? regs_r[i] : {DATA_W{1'b0}});
      wr_hit_s = wr_hit_s | (addr_r == ADDR_W'(i));
    end
  end

  // Register array; out-of-range addresses match no entry and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_s && (addr_r == ADDR_W'(i))) regs_r[i] <= data_nxt_s;
      end
    end
  end

  // Frame FSM, shift registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rw_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      shout_r     <= {DATA_W{1'b0}};
      cipo_r      <= 1'b0;
      cipo_oe_r   <= 1'b0;
      wr_pulse_r  <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      wr_pulse_r  <= 1'b0;
      frame_err_r <= 1'b0;
      cipo_oe_r   <= !ncs_s;
      if (ncs_rise_s) begin
        frame_err_r <= (state_r == ST_CMD) || (state_r == ST_ADDR) || (state_r == ST_DATA);
        state_r     <= ST_IDLE;
        cnt_r       <= {CNT_W{1'b0}};
        rw_r        <= 1'b0;
        addr_r      <= {ADDR_W{1'b0}};
        data_r      <= {DATA_W{1'b0}};
        shout_r     <= {DATA_W{1'b0}};
        cipo_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (ncs_fall_s) begin
              state_r <= ST_CMD;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
          ST_CMD: begin
            if (sample_s) begin
              rw_r    <= copi_s;
              cnt_r   <= cnt_inc_s;
              state_r <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (sample_s) begin
              addr_r <= addr_nxt_s;
              cnt_r  <= cnt_inc_s;
              if (cnt_r == CNT_W'(ADDR_W)) begin
                state_r <= ST_DATA;
                shout_r <= rw_r ? {DATA_W{1'b0}} : rd_val_s;
              end
            end
          end
          ST_DATA: begin
            if (sample_s) begin
              data_r <= data_nxt_s;
              cnt_r  <= cnt_inc_s;
              if (cnt_r == CNT_W'(FRAME_LEN - 1)) begin
                state_r    <= ST_DONE;
                cipo_r     <= 1'b0;
                wr_pulse_r <= commit_s && wr_hit_s;
                if (commit_s && wr_hit_s) wr_addr_r <= addr_r;
              end
            end else if (shift_s && !rw_r) begin
              cipo_r  <= shout_r[DATA_W-1];
              shout_r <= {shout_r[DATA_W-2:0], 1'b0};
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign cipo      = cipo_r;
  assign cipo_oe   = cipo_oe_r;
  assign wr_pulse  = wr_pulse_r;
  assign wr_addr   = wr_addr_r;
  assign frame_err = frame_err_r;
endmodule
